key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_cond_pkg.sv | 21 ++
 rtl/key_debounce_ch.sv | 183 ++++++++++++++++++
 rtl/key_conditioner.sv | 52 +++++
 tb/tb_key_conditioner.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// Shared types and helpers for the key conditioner.
// Holds the per-key debounce state encoding and the ms-to-cycles conversion
// used to size the debounce and auto-repeat timers.
package key_cond_pkg;

   localparam int unsigned NUM_KEYS = 4;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_CHK_PRESS   = 2'd1,
      ST_PRESSED     = 2'd2,
      ST_CHK_RELEASE = 2'd3
   } key_state_e;

   // Integer division first keeps the product inside 32 bits for MHz clocks.
   function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                input int unsigned ms);
      return (clk_hz / 1000) * ms;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: 2-flop synchronizer, 4-state debounce FSM and
// registered level/press/release outputs.
// Optional auto-repeat of the press pulse is compiled in only when
// KEY_COND_AUTOREPEAT_EN is defined; otherwise no repeat logic exists.
module key_debounce_ch
   import key_cond_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 4
`ifdef KEY_COND_AUTOREPEAT_EN
   ,
   parameter int unsigned RPT_DELAY_CYC  = 10,
   parameter int unsigned RPT_PERIOD_CYC = 5
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam int unsigned          CNT_W   = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DB_CYCLES);
   localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);

   logic             sync1_q, sync2_q;
   logic             sample_pressed;
   key_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             rpt_fire;

   // Synchronize the raw button; reset to 1 so a reset looks like "released".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_raw_i;
         sync2_q <= sync1_q;
      end
   end

   // Buttons are active-low on the board.
   assign sample_pressed = ~sync2_q;

   // Debounce state and stability counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: a level change is accepted only after DB_CYCLES stable samples;
   // leaving a CHK state through the terminal count keeps the counter from wrapping.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (sample_pressed) begin
               state_d = ST_CHK_PRESS;
               cnt_d   = CNT_ONE;
            end
         end
         ST_CHK_PRESS: begin
            if (!sample_pressed) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_PRESSED: begin
            if (!sample_pressed) begin
               state_d = ST_CHK_RELEASE;
               cnt_d   = CNT_ONE;
            end
         end
         ST_CHK_RELEASE: begin
            if (sample_pressed) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef KEY_COND_AUTOREPEAT_EN
   localparam int unsigned      RPT_MAX = (RPT_DELAY_CYC > RPT_PERIOD_CYC) ?
                                          RPT_DELAY_CYC : RPT_PERIOD_CYC;
   localparam int unsigned      RPT_W   = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] RPT_DLY = RPT_W'(RPT_DELAY_CYC);
   localparam logic [RPT_W-1:0] RPT_PER = RPT_W'(RPT_PERIOD_CYC);
   localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);

   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             rpt_first_q, rpt_first_d;

   // Repeat timer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_cnt_q   <= '0;
         rpt_first_q <= 1'b1;
      end else begin
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_first_q <= rpt_first_d;
      end
   end

   // Count while held, freeze during a release check, clear otherwise;
   // the first interval is the long delay, later ones the period.
   always_comb begin
      rpt_cnt_d   = rpt_cnt_q;
      rpt_first_d = rpt_first_q;
      rpt_fire    = 1'b0;
      case (state_q)
         ST_PRESSED: begin
            if (rpt_cnt_q == (rpt_first_q ? RPT_DLY : RPT_PER)) begin
               rpt_fire    = 1'b1;
               rpt_cnt_d   = RPT_ONE;
               rpt_first_d = 1'b0;
            end else begin
               rpt_cnt_d = rpt_cnt_q + RPT_ONE;
            end
         end
         ST_CHK_RELEASE: begin
            rpt_cnt_d = rpt_cnt_q;
         end
         default: begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
         end
      endcase
   end
`else
   assign rpt_fire = 1'b0;
`endif

   // Output next-values: edges of the debounced level become one-cycle pulses.
   always_comb begin
      level_d   = (state_q == ST_PRESSED) || (state_q == ST_CHK_RELEASE);
      press_d   = (level_d & ~level_q) | rpt_fire;
      release_d = ~level_d & level_q;
   end

   // Registered outputs, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/key_conditioner.sv
// Four independent debounced push-button channels for the game logic.
// Define KEY_COND_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module key_conditioner
   import key_cond_pkg::*;
#(
   parameter int unsigned CLK_HZ           = 50000000,
   parameter int unsigned DEBOUNCE_MS      = 10,
   parameter int unsigned REPEAT_DELAY_MS  = 400,
   parameter int unsigned REPEAT_PERIOD_MS = 100
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] keys_raw,
   output logic [NUM_KEYS-1:0] keys_level,
   output logic [NUM_KEYS-1:0] keys_press,
   output logic [NUM_KEYS-1:0] keys_release
);

   localparam int unsigned DB_CYCLES      = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int unsigned RPT_DELAY_CYC  = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
   localparam int unsigned RPT_PERIOD_CYC = ms_to_cycles(CLK_HZ, REPEAT_PERIOD_MS);

   // Refuse configurations where the debounce window is too short to filter.
   if (DB_CYCLES < 2) begin : g_bad_debounce
      $error("key_conditioner: DB_CYCLES must be at least 2");
   end

   // Repeat intervals of zero cycles would make the repeat timer meaningless.
   if ((RPT_DELAY_CYC < 1) || (RPT_PERIOD_CYC < 1)) begin : g_bad_repeat
      $error("key_conditioner: repeat delay and period must be at least 1 cycle");
   end

   genvar gi;
   for (gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
      key_debounce_ch #(
         .DB_CYCLES      (DB_CYCLES)
`ifdef KEY_COND_AUTOREPEAT_EN
         ,
         .RPT_DELAY_CYC  (RPT_DELAY_CYC),
         .RPT_PERIOD_CYC (RPT_PERIOD_CYC)
`endif
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .key_raw_i (keys_raw[gi]),
         .level_o   (keys_level[gi]),
         .press_o   (keys_press[gi]),
         .release_o (keys_release[gi])
      );
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner (CLK_HZ=1000, DEBOUNCE_MS=4 -> 4 cycles).
// Expected output events (any press/release pulse) are queued with the edge on
// which they must appear; the monitor pops and compares on every observed event.
module tb_key_conditioner;

   logic       clk;
   logic       rst_n;
   logic [3:0] keys_raw;
   logic [3:0] keys_level;
   logic [3:0] keys_press;
   logic [3:0] keys_release;

   int tests_run    = 0;
   int tests_failed = 0;
   int edge_cnt     = 0;
   int c;

   typedef struct {
      string      tag;
      int         cyc;
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
   } sb_entry_t;

   sb_entry_t sb[$];

   key_conditioner #(
      .CLK_HZ           (1000),
      .DEBOUNCE_MS      (4),
      .REPEAT_DELAY_MS  (10),
      .REPEAT_PERIOD_MS (5)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .keys_raw     (keys_raw),
      .keys_level   (keys_level),
      .keys_press   (keys_press),
      .keys_release (keys_release)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Index of the most recent rising edge.
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int cyc,
                       input logic [3:0] lvl, input logic [3:0] prs, input logic [3:0] rel);
      sb_entry_t e;
      e.tag = tag;
      e.cyc = cyc;
      e.lvl = lvl;
      e.prs = prs;
      e.rel = rel;
      sb.push_back(e);
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if ((keys_press | keys_release) != 4'b0000) begin
         sb_entry_t e;
         $display("[TB] edge=%0d level=%b press=%b release=%b",
                  edge_cnt, keys_level, keys_press, keys_release);
         if (sb.size() == 0) begin
            check_eq("unexpected_evt", {20'd0, keys_level, keys_press, keys_release}, 32'd0);
         end else begin
            e = sb.pop_front();
            check_eq({e.tag, "_edge"},    edge_cnt,     e.cyc);
            check_eq({e.tag, "_level"},   keys_level,   e.lvl);
            check_eq({e.tag, "_press"},   keys_press,   e.prs);
            check_eq({e.tag, "_release"}, keys_release, e.rel);
         end
      end
   end

   initial begin
      keys_raw = 4'hF;
      rst_n    = 1'b0;
      #1;
      check_eq("rst_level",   keys_level,   4'b0000);
      check_eq("rst_press",   keys_press,   4'b0000);
      check_eq("rst_release", keys_release, 4'b0000);
      step(3);
      rst_n = 1'b1;
      step(3);

      // Clean press of key 0: raw sampled on edge c+1, level/pulse on edge c+8.
      c = edge_cnt;
      keys_raw[0] = 1'b0;
      push("t1_press", c + 8, 4'b0001, 4'b0001, 4'b0000);
`ifdef KEY_COND_AUTOREPEAT_EN
      for (int k = 10; k <= 30; k += 5)
         push("t1_rpt", c + 8 + k, 4'b0001, 4'b0001, 4'b0000);
`endif
      step(39);
      keys_raw[0] = 1'b1;
      push("t1_rel", c + 39 + 8, 4'b0000, 4'b0000, 4'b0001);
      step(12);

      // Key 2 bounces every 2 cycles: nothing may come out.
      for (int i = 0; i < 20; i++) begin
         keys_raw[2] = ((i % 4) < 2) ? 1'b0 : 1'b1;
         step(1);
      end
      keys_raw[2] = 1'b1;
      step(12);
      check_eq("t2_level", keys_level, 4'b0000);

      // Key 1 held with a one-cycle release glitch.
      c = edge_cnt;
      keys_raw[1] = 1'b0;
      push("t3_press", c + 8, 4'b0010, 4'b0010, 4'b0000);
      step(10);
      keys_raw[1] = 1'b1;
      step(1);
      keys_raw[1] = 1'b0;
      step(4);
      check_eq("t3_level_held", keys_level, 4'b0010);

      // Reset while key 1 is held: outputs drop at once, then a fresh press.
      rst_n = 1'b0;
      #1;
      check_eq("t5_rst_level",   keys_level,   4'b0000);
      check_eq("t5_rst_press",   keys_press,   4'b0000);
      check_eq("t5_rst_release", keys_release, 4'b0000);
      step(3);
      rst_n = 1'b1;
      // The first edge after deassertion is the sampling edge (edge 0 of the
      // debounce latency), so the pulse lands 7 edges after that one.
      c = edge_cnt;
      push("t5_press", c + 8, 4'b0010, 4'b0010, 4'b0000);
      step(10);
      keys_raw[1] = 1'b1;
      push("t5_rel", c + 18, 4'b0000, 4'b0000, 4'b0010);
      step(14);

      // Keys 0 and 3 together, then key 3 released alone, then key 0.
      c = edge_cnt;
      keys_raw[0] = 1'b0;
      keys_raw[3] = 1'b0;
      push("t4_press", c + 8, 4'b1001, 4'b1001, 4'b0000);
      step(9);
      keys_raw[3] = 1'b1;
      push("t4_rel3", c + 17, 4'b0001, 4'b0000, 4'b1000);
      step(2);
      keys_raw[0] = 1'b1;
      push("t4_rel0", c + 19, 4'b0000, 4'b0000, 4'b0001);
      step(14);
      check_eq("end_level", keys_level, 4'b0000);

      check_eq("sb_left", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
